fifo_arbiter: RTL and testbench
===============================

Name: fifo_arbiter

Overview:
- Shares one 32-bit FIFO between two write requesters and one read requester.
- Sequences the FIFO's single WRH_RDL direction control and issues at most one FIFO operation per cycle.
- Tracks occupancy internally, so grants never overflow or underflow the FIFO.
- Provides a FLUSH sequence that drains the FIFO without delivering data.

Parameters:
- DEPTH, 32, FIFO capacity in words; must match the attached FIFO.
- DW, 32, data width.
- CW, 6, occupancy counter width; must satisfy 2^CW > DEPTH.

Ports:
- CLK  in  1  clock, rising edge.
- RESETH  in  1  synchronous active-high reset.
- WR0_VALID  in  1  writer 0 has a word.
- WR0_DATA  in  DW  writer 0 word.
- WR0_READY  out  1  writer 0 word accepted this cycle (combinational).
- WR1_VALID  in  1  writer 1 has a word.
- WR1_DATA  in  DW  writer 1 word.
- WR1_READY  out  1  writer 1 word accepted this cycle (combinational).
- RD_REQ  in  1  reader requests one word.
- RD_READY  out  1  read request accepted this cycle (combinational).
- RD_VALID  out  1  RD_DATA valid, one-cycle pulse.
- RD_DATA  out  DW  read word.
- FLUSH  in  1  start drain, sampled in ARB only.
- FLUSH_DONE  out  1  one-cycle pulse when drain completes.
- LEVEL  out  CW  internal occupancy count.
- FIFO_EN  out  1  FIFO performs an operation this cycle (registered).
- FIFO_WRH_RDL  out  1  1 = write, 0 = read (registered).
- FIFO_DATAIN  out  DW  write data (registered).
- FIFO_DATAOUT  in  DW  FIFO read data, valid the cycle after a read operation.
- FIFO_FULL  in  1  FIFO full flag.
- FIFO_EMPTY  in  1  FIFO empty flag.

Behaviour:
- Reset (synchronous, RESETH=1 at a rising edge):
  - State ARB, LEVEL=0, all READY=0, RD_VALID=0, FLUSH_DONE=0.
  - FIFO_EN=0, FIFO_WRH_RDL=0, FIFO_DATAIN=0, RD_DATA=0.
  - Writer pointer=0, dir_last=read.
  - The FIFO shares RESETH. Reset mid-operation discards any in-flight word and the pending RD_VALID.
- Eligibility (state ARB only):
  - Write is eligible if any WRx_VALID, LEVEL<DEPTH and !FIFO_FULL.
  - Read is eligible if RD_REQ, LEVEL>0 and !FIFO_EMPTY.
- Arbitration, at most one grant per cycle:
  - If only one direction is eligible, grant it.
  - If both are eligible, grant the direction opposite to dir_last.
  - dir_last updates on every grant.
  - Writers are round-robin: the pointer names the preferred writer. After writer k is granted, the pointer becomes 1-k. If only one writer is valid, it is granted regardless of the pointer.
- Write grant, cycle N:
  - WRk_READY=1 in cycle N.
  - At the cycle N edge: FIFO_EN=1, FIFO_WRH_RDL=1, FIFO_DATAIN=WRk_DATA, LEVEL+1.
- Read grant, cycle N:
  - RD_READY=1 in cycle N.
  - At the cycle N edge: FIFO_EN=1, FIFO_WRH_RDL=0, LEVEL-1.
  - In cycle N+2, RD_VALID=1 and RD_DATA is the FIFO_DATAOUT value sampled at the end of cycle N+1. Total latency is 2 cycles from acceptance.
- Idle cycle: FIFO_EN=0. FIFO_WRH_RDL and FIFO_DATAIN hold their previous values.
- LEVEL changes by at most ±1 per cycle. It never exceeds DEPTH and never goes below 0.
- FSM, ARB:
  - FLUSH=1 moves to DRAIN on the next edge.
  - Grants are still evaluated in the cycle FLUSH is sampled.
- FSM, DRAIN:
  - All READY=0.
  - Each cycle with LEVEL>0: FIFO_EN=1, FIFO_WRH_RDL=0, LEVEL-1.
  - Drain reads never raise RD_VALID, including a drain read that follows a pending normal read.
  - When LEVEL=0: pulse FLUSH_DONE for one cycle, FIFO_EN=0, return to ARB.
  - FLUSH while already in DRAIN is ignored.
- FLUSH with LEVEL=0: DRAIN lasts one cycle, FLUSH_DONE pulses, no FIFO operation is issued.
- Boundaries:
  - At LEVEL=DEPTH both WRx_READY=0.
  - At LEVEL=0 RD_READY=0.
  - VALID or REQ with READY=0 is held by the requester. The block never drops a word.
  - WRx_DATA is sampled only when WRx_READY=1.

Test Plan:
- Writer 0 only, words 1..32 back-to-back, then RD_REQ held for 32 cycles → FIFO_EN=1 for 32 write cycles; LEVEL reaches 32; WR0_READY=0 on the 33rd word; RD_DATA = 1..32 in order, each 2 cycles after RD_READY; LEVEL returns to 0.
- Both writers continuously valid (W0 sends 0xA0.., W1 sends 0xB0..), 8 grants → grant order W0,W1,W0,W1,…; FIFO_DATAIN alternates 0xA0,0xB0,0xA1,0xB1.
- LEVEL=4, writer 0 and reader both requesting for 6 cycles → grants alternate W,R,W,R,W,R; LEVEL ends at 4; no cycle has FIFO_EN with both directions.
- LEVEL=0 with RD_REQ=1 for 5 cycles → RD_READY=0 and FIFO_EN=0 throughout; no RD_VALID.
- Fill to 10, pulse FLUSH → exactly 10 FIFO read cycles with no RD_VALID; then FLUSH_DONE pulses once, LEVEL=0, and READY lines reopen the next cycle.
- Reset asserted the cycle after a read grant → RD_VALID never pulses; LEVEL=0, FIFO_EN=0; writes accepted normally after release.

Source files
------------

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: shares one single-port FIFO between two writers and one reader,
// with occupancy tracking, round-robin writers and a drain (flush) sequence.
module fifo_arbiter #(
    parameter int DEPTH = 32,
    parameter int DW    = 32,
    parameter int CW    = 6
) (
    input  logic          CLK,
    input  logic          RESETH,
    input  logic          WR0_VALID,
    input  logic [DW-1:0] WR0_DATA,
    output logic          WR0_READY,
    input  logic          WR1_VALID,
    input  logic [DW-1:0] WR1_DATA,
    output logic          WR1_READY,
    input  logic          RD_REQ,
    output logic          RD_READY,
    output logic          RD_VALID,
    output logic [DW-1:0] RD_DATA,
    input  logic          FLUSH,
    output logic          FLUSH_DONE,
    output logic [CW-1:0] LEVEL,
    output logic          FIFO_EN,
    output logic          FIFO_WRH_RDL,
    output logic [DW-1:0] FIFO_DATAIN,
    input  logic [DW-1:0] FIFO_DATAOUT,
    input  logic          FIFO_FULL,
    input  logic          FIFO_EMPTY
);

    typedef enum logic {ARB, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] level_q, level_d;
    logic          ptr_q, ptr_d;
    logic          dir_last_q, dir_last_d;
    logic          fifo_en_q, fifo_en_d;
    logic          fifo_wrh_rdl_q, fifo_wrh_rdl_d;
    logic [DW-1:0] fifo_datain_q, fifo_datain_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic wr_elig;
    logic rd_elig;
    logic gnt_w;
    logic gnt_r;
    logic sel1;

    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        ptr_d          = ptr_q;
        dir_last_d     = dir_last_q;
        fifo_en_d      = 1'b0;
        fifo_wrh_rdl_d = fifo_wrh_rdl_q;
        fifo_datain_d  = fifo_datain_q;
        rd_pend_d      = 1'b0;
        rd_valid_d     = rd_pend_q;
        rd_data_d      = rd_pend_q ? FIFO_DATAOUT : rd_data_q;
        WR0_READY      = 1'b0;
        WR1_READY      = 1'b0;
        RD_READY       = 1'b0;
        FLUSH_DONE     = 1'b0;

        // Readies are held low while reset is asserted so no word is lost.
        wr_elig = (state_q == ARB) && !RESETH && (WR0_VALID || WR1_VALID)
                  && (level_q < CW'(DEPTH)) && !FIFO_FULL;
        rd_elig = (state_q == ARB) && !RESETH && RD_REQ
                  && (level_q != '0) && !FIFO_EMPTY;
        gnt_w   = wr_elig && (!rd_elig || !dir_last_q);
        gnt_r   = rd_elig && (!wr_elig || dir_last_q);
        sel1    = WR1_VALID && (!WR0_VALID || ptr_q);

        unique case (state_q)
            ARB: begin
                if (gnt_w) begin
                    WR0_READY      = !sel1;
                    WR1_READY      = sel1;
                    fifo_en_d      = 1'b1;
                    fifo_wrh_rdl_d = 1'b1;
                    fifo_datain_d  = sel1 ? WR1_DATA : WR0_DATA;
                    level_d        = level_q + CW'(1);
                    ptr_d          = !sel1;
                    dir_last_d     = 1'b1;
                end else if (gnt_r) begin
                    RD_READY       = 1'b1;
                    fifo_en_d      = 1'b1;
                    fifo_wrh_rdl_d = 1'b0;
                    level_d        = level_q - CW'(1);
                    dir_last_d     = 1'b0;
                    rd_pend_d      = 1'b1;
                end
                if (FLUSH) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (level_q != '0) begin
                    fifo_en_d      = 1'b1;
                    fifo_wrh_rdl_d = 1'b0;
                    level_d        = level_q - CW'(1);
                end else begin
                    FLUSH_DONE = 1'b1;
                    state_d    = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESETH) begin
            state_q        <= ARB;
            level_q        <= '0;
            ptr_q          <= 1'b0;
            dir_last_q     <= 1'b0;
            fifo_en_q      <= 1'b0;
            fifo_wrh_rdl_q <= 1'b0;
            fifo_datain_q  <= '0;
            rd_pend_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            ptr_q          <= ptr_d;
            dir_last_q     <= dir_last_d;
            fifo_en_q      <= fifo_en_d;
            fifo_wrh_rdl_q <= fifo_wrh_rdl_d;
            fifo_datain_q  <= fifo_datain_d;
            rd_pend_q      <= rd_pend_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign LEVEL        = level_q;
    assign FIFO_EN      = fifo_en_q;
    assign FIFO_WRH_RDL = fifo_wrh_rdl_q;
    assign FIFO_DATAIN  = fifo_datain_q;
    assign RD_VALID     = rd_valid_q;
    assign RD_DATA      = rd_data_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a show-ahead FIFO model attached.
module tb_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reseth;
    logic        wr0_valid, wr1_valid, rd_req, flush;
    logic [31:0] wr0_data, wr1_data;
    logic        wr0_ready, wr1_ready, rd_ready, rd_valid, flush_done;
    logic [31:0] rd_data;
    logic [5:0]  level;
    logic        fifo_en, fifo_wrh_rdl;
    logic [31:0] fifo_datain, fifo_dataout;
    logic        fifo_full, fifo_empty;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [32];
    logic [4:0]  wp, rp;
    logic [5:0]  cnt;

    always #5 clk = ~clk;

    fifo_arbiter dut (
        .CLK(clk), .RESETH(reseth),
        .WR0_VALID(wr0_valid), .WR0_DATA(wr0_data), .WR0_READY(wr0_ready),
        .WR1_VALID(wr1_valid), .WR1_DATA(wr1_data), .WR1_READY(wr1_ready),
        .RD_REQ(rd_req), .RD_READY(rd_ready), .RD_VALID(rd_valid),
        .RD_DATA(rd_data), .FLUSH(flush), .FLUSH_DONE(flush_done),
        .LEVEL(level), .FIFO_EN(fifo_en), .FIFO_WRH_RDL(fifo_wrh_rdl),
        .FIFO_DATAIN(fifo_datain), .FIFO_DATAOUT(fifo_dataout),
        .FIFO_FULL(fifo_full), .FIFO_EMPTY(fifo_empty)
    );

    // FIFO model: head word always visible, one operation per enabled cycle.
    always @(posedge clk) begin
        if (reseth) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (fifo_en) begin
            if (fifo_wrh_rdl && cnt < 6'd32) begin
                mem[wp] <= fifo_datain;
                wp      <= wp + 5'd1;
                cnt     <= cnt + 6'd1;
            end else if (!fifo_wrh_rdl && cnt != 6'd0) begin
                rp  <= rp + 5'd1;
                cnt <= cnt - 6'd1;
            end
        end
    end

    assign fifo_dataout = mem[rp];
    assign fifo_full    = (cnt == 6'd32);
    assign fifo_empty   = (cnt == 6'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reseth = 1'b1;
        tick();
        reseth = 1'b0;
    endtask

    task automatic test_reset();
        reseth = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({level, fifo_en, fifo_wrh_rdl, rd_valid, flush_done} !== 10'd0) begin
            bad++;
            $display("FAIL reset_ctl got=%0h want=0",
                     {level, fifo_en, fifo_wrh_rdl, rd_valid, flush_done});
        end
        total++;
        if ({fifo_datain, rd_data} !== 64'd0) begin
            bad++;
            $display("FAIL reset_data got=%0h/%0h want=0", fifo_datain, rd_data);
        end
        total++;
        if ({wr0_ready, wr1_ready, rd_ready} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ready got=%b want=000", {wr0_ready, wr1_ready, rd_ready});
        end
        tick();
        reseth = 1'b0;
    endtask

    task automatic test_fill_drain();
        int word = 1;
        int en_w = 0;
        wr0_valid = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            wr0_data = word;
            @(negedge clk);
            if (c < 32) begin
                total++;
                if (wr0_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL fill_ready c=%0d got=%b want=1", c, wr0_ready);
                end
            end else begin
                total++;
                if (wr0_ready !== 1'b0 || level !== 6'd32) begin
                    bad++;
                    $display("FAIL full_block got=%b lvl=%0d want=0 lvl=32", wr0_ready, level);
                end
            end
            if (c >= 1 && fifo_en === 1'b1 && fifo_wrh_rdl === 1'b1) en_w++;
            if (wr0_ready === 1'b1) word++;
            tick();
        end
        wr0_valid = 1'b0;
        total++;
        if (en_w != 32) begin
            bad++;
            $display("FAIL fill_en_count got=%0d want=32", en_w);
        end
        for (int c = 0; c < 36; c++) begin
            logic exp_v;
            rd_req = (c < 32);
            exp_v = (c >= 2 && c < 34);
            @(negedge clk);
            if (c < 32) begin
                total++;
                if (rd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL drain_ready c=%0d got=%b want=1", c, rd_ready);
                end
            end
            total++;
            if (rd_valid !== exp_v || (exp_v && rd_data !== 32'(c - 1))) begin
                bad++;
                $display("FAIL read_data c=%0d got=%b/%0d want=%b/%0d",
                         c, rd_valid, rd_data, exp_v, c - 1);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (level !== 6'd0) begin
            bad++;
            $display("FAIL drain_level got=%0d want=0", level);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] d0 = 32'hA0;
        logic [31:0] d1 = 32'hB0;
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            wr0_valid = (c < 8);
            wr1_valid = (c < 8);
            wr0_data  = d0;
            wr1_data  = d1;
            @(negedge clk);
            if (c < 8) begin
                total++;
                if (wr0_ready !== (c % 2 == 0) || wr1_ready !== (c % 2 == 1)) begin
                    bad++;
                    $display("FAIL rr_grant c=%0d got=%b%b", c, wr0_ready, wr1_ready);
                end
            end
            if (c >= 1) begin
                logic [31:0] exp;
                exp = ((c - 1) % 2 == 0) ? 32'hA0 + 32'((c - 1) / 2)
                                         : 32'hB0 + 32'((c - 1) / 2);
                total++;
                if (fifo_en !== 1'b1 || fifo_datain !== exp) begin
                    bad++;
                    $display("FAIL rr_datain c=%0d got=%0h want=%0h", c, fifo_datain, exp);
                end
            end
            if (wr0_ready === 1'b1) d0++;
            if (wr1_ready === 1'b1) d1++;
            tick();
        end
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 6'd8) begin
            bad++;
            $display("FAIL rr_level got=%0d want=8", level);
        end
        tick();
    endtask

    task automatic test_alternate();
        rd_req = 1'b1;
        repeat (4) tick();
        rd_req = 1'b0;
        repeat (3) tick();
        for (int c = 0; c <= 6; c++) begin
            wr0_valid = (c < 6);
            rd_req    = (c < 6);
            wr0_data  = 32'hC0 + 32'(c);
            @(negedge clk);
            if (c < 6) begin
                total++;
                if (wr0_ready !== (c % 2 == 0) || rd_ready !== (c % 2 == 1)) begin
                    bad++;
                    $display("FAIL alt_grant c=%0d got=w%b r%b", c, wr0_ready, rd_ready);
                end
            end
            if (c >= 1) begin
                total++;
                if (fifo_en !== 1'b1 || fifo_wrh_rdl !== ((c - 1) % 2 == 0)) begin
                    bad++;
                    $display("FAIL alt_dir c=%0d got=%b%b", c, fifo_en, fifo_wrh_rdl);
                end
            end
            if (c == 3 || c == 5) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== (c == 3 ? 32'hA2 : 32'hB2)) begin
                    bad++;
                    $display("FAIL alt_rdata c=%0d got=%b/%0h", c, rd_valid, rd_data);
                end
            end
            tick();
        end
        wr0_valid = 1'b0;
        rd_req    = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 6'd4) begin
            bad++;
            $display("FAIL alt_level got=%0d want=4", level);
        end
        tick();
    endtask

    task automatic test_empty_read();
        apply_reset();
        rd_req = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) rd_req = 1'b0;
            @(negedge clk);
            total++;
            if (rd_ready !== 1'b0 || fifo_en !== 1'b0 || rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL empty_read c=%0d got=%b%b%b want=000",
                         c, rd_ready, fifo_en, rd_valid);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int nrd = 0;
        int nv = 0;
        int nd = 0;
        apply_reset();
        wr0_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wr0_data = 32'h100 + 32'(c);
            tick();
        end
        wr0_valid = 1'b0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (level !== 6'd10) begin
            bad++;
            $display("FAIL flush_start got=%0d want=10", level);
        end
        tick();
        flush     = 1'b0;
        wr0_valid = 1'b1;
        wr0_data  = 32'h55;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_en === 1'b1 && fifo_wrh_rdl === 1'b0) nrd++;
            if (rd_valid === 1'b1) nv++;
            if (flush_done === 1'b1) nd++;
            total++;
            if (flush_done !== (i == 10) || wr0_ready !== (i == 11)) begin
                bad++;
                $display("FAIL flush_seq i=%0d got=done%b rdy%b", i, flush_done, wr0_ready);
            end
            if (i == 10) begin
                total++;
                if (level !== 6'd0) begin
                    bad++;
                    $display("FAIL flush_level got=%0d want=0", level);
                end
            end
            tick();
        end
        wr0_valid = 1'b0;
        total++;
        if (nrd != 10 || nv != 0 || nd != 1) begin
            bad++;
            $display("FAIL flush_counts got=rd%0d v%0d d%0d want=10/0/1", nrd, nv, nd);
        end
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        wr0_valid = 1'b1;
        wr0_data  = 32'h33;
        repeat (3) tick();
        wr0_valid = 1'b0;
        repeat (2) tick();
        rd_req = 1'b1;
        @(negedge clk);
        total++;
        if (rd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_rd_grant got=%b want=1", rd_ready);
        end
        tick();
        rd_req = 1'b0;
        reseth = 1'b1;
        tick();
        reseth = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (rd_valid !== 1'b0 || level !== 6'd0 || fifo_en !== 1'b0) begin
                bad++;
                $display("FAIL rst_inflight i=%0d got=v%b l%0d en%b", i, rd_valid, level, fifo_en);
            end
            tick();
        end
        wr0_valid = 1'b1;
        wr0_data  = 32'h77;
        @(negedge clk);
        total++;
        if (wr0_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_wr_ready got=%b want=1", wr0_ready);
        end
        tick();
        wr0_valid = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 6'd1 || fifo_en !== 1'b1 || fifo_datain !== 32'h77) begin
            bad++;
            $display("FAIL rst_wr_after got=l%0d en%b d%0h want=1/1/77", level, fifo_en, fifo_datain);
        end
        tick();
    endtask

    initial begin
        reseth    = 1'b1;
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        wr0_data  = '0;
        wr1_data  = '0;
        rd_req    = 1'b0;
        flush     = 1'b0;
        test_reset();
        test_fill_drain();
        test_round_robin();
        test_alternate();
        test_empty_read();
        test_flush();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
